// File: rtl/issue_select.sv
// Round-robin issue select for the reservation station, followed by a fixed-latency
// FU pipeline model that reports completions as retire index and one-hot wakeup mask.
module issue_select #(
  parameter int RS_ENTRIES = 8,
  parameter int EXEC_LAT   = 3,
  localparam int IDX_W     = (RS_ENTRIES > 1) ? $clog2(RS_ENTRIES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RS_ENTRIES-1:0] reqs,
  input  logic                  exec_stall,
  input  logic                  flush,
  output logic [RS_ENTRIES-1:0] grant,
  output logic                  grant_valid,
  output logic [RS_ENTRIES-1:0] ready_mask,
  output logic [IDX_W-1:0]      retire_entry,
  output logic                  retire_valid
);

  localparam int LAST = EXEC_LAT - 1;

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] cand;
  logic             found;
  int               cand_w;

  logic             stage_v   [EXEC_LAT];
  logic [IDX_W-1:0] stage_idx [EXEC_LAT];

  // Scan starts at ptr and wraps; the first requester found wins.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    cand_w  = 0;
    cand    = '0;
    for (int k = 0; k < RS_ENTRIES; k++) begin
      cand_w = (int'(ptr) + k) % RS_ENTRIES;
      cand   = IDX_W'(cand_w);
      if (!found && reqs[cand]) begin
        found   = 1'b1;
        sel_idx = cand;
      end
    end
  end

  // rst gating keeps the combinational grant quiet while reset is held.
  assign grant_valid = rst & found & ~exec_stall & ~flush;
  assign grant       = grant_valid ? (RS_ENTRIES'(1) << sel_idx) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (flush) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= (sel_idx == IDX_W'(RS_ENTRIES - 1)) ? '0 : sel_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < EXEC_LAT; k++) begin
        stage_v[k]   <= 1'b0;
        stage_idx[k] <= '0;
      end
    end else if (flush) begin
      for (int k = 0; k < EXEC_LAT; k++) begin
        stage_v[k] <= 1'b0;
      end
    end else if (!exec_stall) begin
      stage_v[0]   <= grant_valid;
      stage_idx[0] <= sel_idx;
      for (int k = 1; k < EXEC_LAT; k++) begin
        stage_v[k]   <= stage_v[k-1];
        stage_idx[k] <= stage_idx[k-1];
      end
    end
  end

  // The last stage only drains on an advancing edge, so each op retires once.
  assign retire_valid = stage_v[LAST] & ~exec_stall & ~flush;
  assign retire_entry = retire_valid ? stage_idx[LAST] : '0;
  assign ready_mask   = retire_valid ? (RS_ENTRIES'(1) << stage_idx[LAST]) : '0;

endmodule

// File: tb/tb_issue_select.sv
// Randomized and directed bench for issue_select with a queue-based reference model
// and a scoreboard monitor that checks every grant and retire as it appears.
module tb_issue_select;

  localparam int N = 8;
  localparam int L = 3;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  reqs = '1;
  logic          exec_stall = 1'b0;
  logic          flush = 1'b0;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [N-1:0]  ready_mask;
  logic [IW-1:0] retire_entry;
  logic          retire_valid;

  issue_select #(.RS_ENTRIES(N), .EXEC_LAT(L)) dut (
    .clk(clk), .rst(rst), .reqs(reqs), .exec_stall(exec_stall), .flush(flush),
    .grant(grant), .grant_valid(grant_valid), .ready_mask(ready_mask),
    .retire_entry(retire_entry), .retire_valid(retire_valid)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int idx; } ev_t;
  typedef struct { int idx; int age; } op_t;

  ev_t exp_g[$];
  ev_t exp_r[$];
  op_t infl[$];
  int  m_ptr = 0;
  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: ops age by one per advancing edge and complete once aged L.
  task automatic model_cycle();
    bit gv, rv;
    int gidx, j;
    ev_t e;
    op_t o;
    gv = 0; gidx = -1;
    if (!exec_stall && !flush) begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (gidx < 0 && reqs[j]) gidx = j;
      end
      gv = (gidx >= 0);
    end
    rv = (infl.size() > 0) && (infl[0].age == L) && !exec_stall && !flush;
    if (gv) begin e.cyc = cyc; e.idx = gidx; exp_g.push_back(e); end
    if (rv) begin e.cyc = cyc; e.idx = infl[0].idx; exp_r.push_back(e); end
    if (flush) begin
      infl.delete();
      m_ptr = 0;
    end else if (!exec_stall) begin
      if (rv) void'(infl.pop_front());
      foreach (infl[i]) infl[i].age++;
      if (gv) begin
        o.idx = gidx; o.age = 1; infl.push_back(o);
        m_ptr = (gidx + 1) % N;
      end
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic s, input logic f);
    @(posedge clk); #1;
    reqs = r; exec_stall = s; flush = f;
    model_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_grant"}, int'(grant), 0);
    chk({tag, "_grant_valid"}, int'(grant_valid), 0);
    chk({tag, "_ready_mask"}, int'(ready_mask), 0);
    chk({tag, "_retire_entry"}, int'(retire_entry), 0);
    chk({tag, "_retire_valid"}, int'(retire_valid), 0);
  endtask

  task automatic mid_reset();
    @(posedge clk); #1;
    reqs = '1; exec_stall = 1'b0; flush = 1'b0;
    #2 rst = 1'b0;
    #1 check_all_zero("async_reset");
    infl.delete();
    m_ptr = 0;
    repeat (2) @(posedge clk);
    #1 check_all_zero("held_reset");
    rst = 1'b1; reqs = '0;
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(negedge clk) begin
    ev_t e;
    if (rst) begin
      while (exp_g.size() > 0 && exp_g[0].cyc < cyc) begin
        e = exp_g.pop_front();
        chk("grant_missing", -1, e.idx);
      end
      while (exp_r.size() > 0 && exp_r[0].cyc < cyc) begin
        e = exp_r.pop_front();
        chk("retire_missing", -1, e.idx);
      end
      chk("grant_onehot0", int'($onehot0(grant)), 1);
      if (grant_valid) begin
        if (exp_g.size() == 0) chk("grant_unexpected", onehot_idx(grant), -1);
        else begin
          e = exp_g.pop_front();
          chk("grant_cycle", cyc, e.cyc);
          chk("grant_idx", onehot_idx(grant), e.idx);
        end
      end else chk("grant_zero_when_invalid", int'(grant), 0);
      if (retire_valid) begin
        chk("ready_mask_matches_entry", int'(ready_mask), 1 << retire_entry);
        if (exp_r.size() == 0) chk("retire_unexpected", int'(retire_entry), -1);
        else begin
          e = exp_r.pop_front();
          chk("retire_cycle", cyc, e.cyc);
          chk("retire_entry", int'(retire_entry), e.idx);
        end
      end else begin
        chk("ready_mask_zero_when_invalid", int'(ready_mask), 0);
        chk("retire_entry_zero_when_invalid", int'(retire_entry), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] r;
    logic s, f;
    #3 check_all_zero("reset_state");
    @(posedge clk); #1;
    rst = 1'b1; reqs = '0;

    for (int i = 0; i < 9; i++) step('1, 1'b0, 1'b0);
    idle(4);
    step(8'b0000_0100, 1'b0, 1'b0);
    idle(4);
    step(8'b0100_0000, 1'b0, 1'b0);
    step(8'b1000_0001, 1'b0, 1'b0);
    step(8'b0000_0001, 1'b0, 1'b0);
    idle(4);
    step(8'b0000_1000, 1'b0, 1'b0);
    step('1, 1'b1, 1'b0);
    step('1, 1'b1, 1'b0);
    idle(5);
    step(8'b0000_0001, 1'b0, 1'b0);
    step(8'b0000_0010, 1'b0, 1'b0);
    step(8'b0000_0100, 1'b0, 1'b0);
    step('0, 1'b0, 1'b1);
    idle(L + 1);
    step('1, 1'b0, 1'b0);
    idle(4);
    step('1, 1'b0, 1'b0);
    step('1, 1'b0, 1'b0);
    mid_reset();
    idle(L + 2);

    for (int i = 0; i < 3000; i++) begin
      r = N'($urandom);
      if ($urandom_range(0, 3) == 0) r = '0;
      s = ($urandom_range(0, 7) == 0);
      f = ($urandom_range(0, 24) == 0);
      step(r, s, f);
      if (i == 1500) begin
        mid_reset();
      end
    end
    idle(L + 3);
    @(negedge clk); #1;
    chk("grant_queue_drained", exp_g.size(), 0);
    chk("retire_queue_drained", exp_r.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
